// File: rtl/da_fir_pkg.sv
// Shared types and width helpers for the distributed-arithmetic FIR engine.
// Holds the controller state encoding and the derived-width functions.
package da_fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int lut_w(input int coef_w, input int k);
        return coef_w + k;
    endfunction

    function automatic int acc_w(input int data_w, input int coef_w,
                                 input int taps);
        return data_w + coef_w + clog2(taps);
    endfunction

endpackage

// File: rtl/da_lut.sv
// One distributed-arithmetic partial-sum table: register array with a
// synchronous write port and a combinational read port.
module da_lut
    import da_fir_pkg::*;
#(
    parameter int LUT_K = 4,
    parameter int LUT_W = lut_w(16, 4)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we,
    input  logic [LUT_K-1:0] waddr,
    input  logic [LUT_W-1:0] wdata,
    input  logic [LUT_K-1:0] raddr,
    output logic [LUT_W-1:0] rdata
);

    logic [LUT_W-1:0] mem [2**LUT_K];

    // Table storage: cleared on reset, written one entry at a time.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2**LUT_K; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/da_fir_engine.sv
// Bit-serial distributed-arithmetic FIR: one sample per DATA_W+1 cycles.
// Optional output saturation to OUT_W bits when DA_FIR_SAT_EN is defined.
module da_fir_engine
    import da_fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 64,
    parameter int LUT_K  = 4,
    parameter int OUT_W  = 16
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [DATA_W-1:0]                     din,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [acc_w(DATA_W,COEF_W,TAPS)-1:0]  dout,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    input  logic                                  lut_we,
    input  logic [idx_w(TAPS/LUT_K)-1:0]          lut_sel,
    input  logic [LUT_K-1:0]                      lut_addr,
    input  logic [lut_w(COEF_W,LUT_K)-1:0]        lut_data,
    input  logic                                  flush,
    output logic                                  ovf
);

    localparam int NLUT  = TAPS / LUT_K;
    localparam int LUT_W = lut_w(COEF_W, LUT_K);
    localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
    localparam int SEL_W = idx_w(NLUT);
    localparam int BW    = idx_w(DATA_W);

    state_t state, state_nx;

    logic [DATA_W-1:0]       taps [TAPS];
    logic [BW-1:0]           b;
    logic signed [LUT_W-1:0] rdata [NLUT];
    logic signed [ACC_W-1:0] acc, acc_nx, psum, dout_nx;
    logic                    accept, last, flush_ok, lut_en, ovf_nx;

    assign accept   = in_valid & in_ready;
    assign last     = (b == BW'(DATA_W - 1));
    assign flush_ok = flush & (state == IDLE);
    assign lut_en   = lut_we & (state == IDLE);

    for (genvar j = 0; j < NLUT; j++) begin : g_lut
        logic [LUT_K-1:0] addr;

        // Address bit n is bit-plane b of tap j*LUT_K+n.
        always_comb begin
            addr = '0;
            for (int n = 0; n < LUT_K; n++) addr[n] = taps[j*LUT_K+n][b];
        end

        da_lut #(
            .LUT_K (LUT_K),
            .LUT_W (LUT_W)
        ) u_lut (
            .clk   (clk),
            .rstn  (rstn),
            .we    (lut_en && (lut_sel == SEL_W'(j))),
            .waddr (lut_addr),
            .wdata (lut_data),
            .raddr (addr),
            .rdata (rdata[j])
        );
    end

    // Partial sum of all tables; MSB plane carries negative weight.
    always_comb begin
        psum = '0;
        for (int j = 0; j < NLUT; j++) psum += ACC_W'(rdata[j]);
        acc_nx = last ? acc - (psum <<< b) : acc + (psum <<< b);
    end

`ifdef DA_FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SMAX =
        ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

    // Clip the final sum to the signed OUT_W range.
    always_comb begin
        dout_nx = acc_nx;
        ovf_nx  = 1'b0;
        if (acc_nx > SMAX) begin
            dout_nx = SMAX;
            ovf_nx  = 1'b1;
        end else if (acc_nx < SMIN) begin
            dout_nx = SMIN;
            ovf_nx  = 1'b1;
        end
    end
`else
    // Full-precision result, no clipping.
    always_comb begin
        dout_nx = acc_nx;
        ovf_nx  = 1'b0;
    end
`endif

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and sample-side ready.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ACCUM;
            end
            ACCUM: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) state_nx = in_valid ? ACCUM : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Delay line: flush in IDLE clears it before any new sample lands.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < TAPS; i++) taps[i] <= '0;
        end else if (accept) begin
            taps[0] <= din;
            for (int i = 1; i < TAPS; i++)
                taps[i] <= flush_ok ? '0 : taps[i-1];
        end else if (flush_ok) begin
            for (int i = 0; i < TAPS; i++) taps[i] <= '0;
        end
    end

    // Bit-serial accumulator and registered result handshake.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc       <= '0;
            b         <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                acc <= '0;
                b   <= '0;
            end else if (state == ACCUM) begin
                acc <= acc_nx;
                b   <= b + 1'b1;
            end
            if (state == ACCUM && last) begin
                dout      <= dout_nx;
                ovf       <= ovf_nx;
                out_valid <= 1'b1;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_da_fir_engine.sv
// Self-checking bench for da_fir_engine against a direct-form FIR model.
// Saturation cases run only when DA_FIR_SAT_EN is defined.
module tb_da_fir_engine;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 64;
    localparam int LUT_K  = 4;
    localparam int OUT_W  = 16;
    localparam int NLUT   = TAPS / LUT_K;
    localparam int LUT_W  = COEF_W + LUT_K;
    localparam int ACC_W  = DATA_W + COEF_W + 6;
    localparam int SEL_W  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn, in_valid, in_ready, out_valid, out_ready;
    logic              lut_we, flush, ovf;
    logic [DATA_W-1:0] din;
    logic [ACC_W-1:0]  dout;
    logic [SEL_W-1:0]  lut_sel;
    logic [LUT_K-1:0]  lut_addr;
    logic [LUT_W-1:0]  lut_data;

    int     n_run  = 0;
    int     n_fail = 0;
    longint coef [TAPS];
    longint dl   [TAPS];
    longint exp_v;
    longint held;
    logic   exp_o;

    da_fir_engine #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .LUT_K  (LUT_K),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lut_we    (lut_we),
        .lut_sel   (lut_sel),
        .lut_addr  (lut_addr),
        .lut_data  (lut_data),
        .flush     (flush),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input longint got,
                       input longint want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Direct convolution y = sum coef[i]*x[n-i], optionally clipped.
    function automatic void model(output longint v, output logic o);
        longint s = 0;
        longint hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        for (int i = 0; i < TAPS; i++) s += coef[i] * dl[i];
        v = s;
        o = 1'b0;
`ifdef DA_FIR_SAT_EN
        if (s > hi) begin
            v = hi;
            o = 1'b1;
        end else if (s < -hi - 1) begin
            v = -hi - 1;
            o = 1'b1;
        end
`else
        if (hi < 0) o = 1'b1;
`endif
    endfunction

    task automatic load_coefs();
        longint s;
        for (int j = 0; j < NLUT; j++) begin
            for (int a = 0; a < (1 << LUT_K); a++) begin
                s = 0;
                for (int n = 0; n < LUT_K; n++)
                    if (a[n]) s += coef[j*LUT_K+n];
                @(negedge clk);
                lut_we   = 1'b1;
                lut_sel  = SEL_W'(j);
                lut_addr = LUT_K'(a);
                lut_data = LUT_W'(s);
            end
        end
        @(negedge clk);
        lut_we = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < TAPS; i++) dl[i] = 0;
    endtask

    // Push one sample, wait for the result and compare it (not consumed).
    task automatic start(input logic [DATA_W-1:0] x, input string tag);
        int n;
        for (int i = TAPS - 1; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = longint'($signed(x));
        model(exp_v, exp_o);
        @(negedge clk);
        din      = x;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".vld"}, longint'(out_valid), 1);
        chk({tag, ".dout"}, longint'($signed(dout)), exp_v);
        chk({tag, ".ovf"}, longint'(ovf), longint'(exp_o));
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        lut_we = 1'b0; flush = 1'b0; din = '0;
        lut_sel = '0; lut_addr = '0; lut_data = '0;
        for (int i = 0; i < TAPS; i++) begin
            coef[i] = 0;
            dl[i]   = 0;
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", longint'(in_ready), 1);
        chk("rst.out_valid", longint'(out_valid), 0);
        chk("rst.dout", longint'(dout), 0);
        chk("rst.ovf", longint'(ovf), 0);

        // Unit coefficients: running sums and MSB-plane subtraction.
        for (int i = 0; i < TAPS; i++) coef[i] = 1;
        load_coefs();
        do_flush();
        start(16'd100, "ones100");
        chk("ones100.c", longint'($signed(dout)), 100);
        consume();
        start(16'd5, "ones105");
        chk("ones105.c", longint'($signed(dout)), 105);
        consume();
        do_flush();
        start(16'hFFFF, "neg1");
        chk("neg1.c", longint'($signed(dout)), -1);
        consume();

        // Ramp coefficients: impulse walks through each tap.
        for (int i = 0; i < TAPS; i++) coef[i] = i + 1;
        load_coefs();
        do_flush();
        for (int k = 0; k < TAPS; k++) begin
            start((k == 0) ? 16'd1 : 16'd0, $sformatf("imp%0d", k));
            chk($sformatf("imp%0d.c", k), longint'($signed(dout)), k + 1);
            consume();
        end

        // Back-pressure in DONE: outputs held, no accept, no table write.
        do_flush();
        start(16'd7, "hold");
        held = longint'($signed(dout));
        @(negedge clk);
        in_valid = 1'b1; din = 16'd999;
        lut_we = 1'b1; lut_sel = '0; lut_addr = 4'd1; lut_data = 20'd12345;
        repeat (10) @(negedge clk);
        chk("hold.in_ready", longint'(in_ready), 0);
        chk("hold.vld", longint'(out_valid), 1);
        chk("hold.dout", longint'($signed(dout)), held);
        in_valid = 1'b0;
        lut_we   = 1'b0;
        consume();
        do_flush();
        start(16'd1, "readback");
        chk("readback.c", longint'($signed(dout)), 1);
        consume();

        // Random coefficients and samples.
        for (int i = 0; i < TAPS; i++)
            coef[i] = longint'($signed(16'($urandom)));
        load_coefs();
        do_flush();
        for (int r = 0; r < 24; r++) begin
            start(16'($urandom), $sformatf("rnd%0d", r));
            consume();
        end

        // Reset while accumulating abandons the result and clears tables.
        @(negedge clk);
        din = 16'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("mrst.in_ready", longint'(in_ready), 1);
        chk("mrst.vld", longint'(out_valid), 0);
        repeat (20) @(negedge clk);
        chk("mrst.novld", longint'(out_valid), 0);
        for (int i = 0; i < TAPS; i++) begin
            coef[i] = 0;
            dl[i]   = 0;
        end
        start(16'd1, "mrst.imp");
        chk("mrst.imp.c", longint'($signed(dout)), 0);
        consume();

`ifdef DA_FIR_SAT_EN
        coef[0] = 32767;
        coef[1] = 32767;
        load_coefs();
        do_flush();
        start(16'd32767, "sat1");
        consume();
        start(16'd32767, "sat2");
        chk("sat2.c", longint'($signed(dout)), 32767);
        chk("sat2.ovf", longint'(ovf), 1);
        consume();
        do_flush();
        start(16'd0, "sat0");
        chk("sat0.c", longint'($signed(dout)), 0);
        chk("sat0.ovf", longint'(ovf), 0);
        consume();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
